// File: rtl/start_io_ctrl.sv
// Start button synchronizer, debouncer and request latch.
// The CPU polls the request at IO_ADDR and acks it with a store there.
module start_io_ctrl #(
  parameter int WIDTH           = 32,
  parameter int IO_ADDR         = 204,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             we,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] wd,
  output logic             startIO,
  output logic             btn_stable,
  output logic [7:0]       start_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IO_A = WIDTH'(IO_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    WAIT_REL
  } state_t;

  state_t           state, nxt;
  logic             s1, s2;
  logic             btn_stable_q;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic             hit;
  logic             sw_set, sw_clr;
  logic             inc;

  // two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // accept a level change only after it holds for DEBOUNCE_CYCLES
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      btn_stable <= 1'b0;
    end else if (s2 == btn_stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt        <= '0;
      btn_stable <= s2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // delayed copy for rising-edge detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_stable_q <= 1'b0;
    else      btn_stable_q <= btn_stable;
  end

  assign press  = btn_stable & ~btn_stable_q;
  assign hit    = we && (a2 == IO_A);
  assign sw_set = hit & wd[0];
  assign sw_clr = hit & ~wd[0];

  // request state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // next state; a held button never re-triggers from WAIT_REL
  always_comb begin
    nxt = state;
    inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (press || sw_set) begin
          nxt = ACTIVE;
          inc = 1'b1;
        end
      end
      ACTIVE: begin
        if (sw_clr) nxt = btn_stable ? WAIT_REL : IDLE;
      end
      WAIT_REL: begin
        if (sw_set) begin
          nxt = ACTIVE;
          inc = 1'b1;
        end else if (!btn_stable) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // saturating count of accepted requests
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            start_count <= 8'd0;
    else if (inc && start_count != 8'hFF) start_count <= start_count + 8'd1;
  end

  assign startIO = (state == ACTIVE);

endmodule

// File: tb/tb_start_io_ctrl.sv
// Directed bench for start_io_ctrl with DEBOUNCE_CYCLES=4.
// Vector table for bus decode, hand sequences for debounce/reset/saturation.
module tb_start_io_ctrl;

  localparam int D = 4;

  logic        clk;
  logic        rst;
  logic        btn_in;
  logic        we;
  logic [31:0] a2;
  logic [31:0] wd;
  logic        startIO;
  logic        btn_stable;
  logic [7:0]  start_count;

  int total;
  int bad;
  int c;

  typedef struct {
    logic        we;
    logic [31:0] a2;
    logic [31:0] wd;
    logic        exp_s;
    logic [7:0]  exp_c;
  } vec_t;

  vec_t tbl[14];

  start_io_ctrl #(
    .WIDTH(32),
    .IO_ADDR(204),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .we(we),
    .a2(a2),
    .wd(wd),
    .startIO(startIO),
    .btn_stable(btn_stable),
    .start_count(start_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a,
                     input logic [31:0] d);
    we = w;
    a2 = a;
    wd = d;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    btn_in = 1'b0;
    bus(1'b0, 32'd0, 32'd0);

    tbl[0]  = '{1'b1, 32'd203,       32'd1,           1'b0, 8'd2};
    tbl[1]  = '{1'b0, 32'd204,       32'd1,           1'b0, 8'd2};
    tbl[2]  = '{1'b1, 32'd204,       32'd0,           1'b0, 8'd2};
    tbl[3]  = '{1'b1, 32'd204,       32'd1,           1'b1, 8'd3};
    tbl[4]  = '{1'b1, 32'd204,       32'd1,           1'b1, 8'd3};
    tbl[5]  = '{1'b0, 32'd0,         32'd0,           1'b1, 8'd3};
    tbl[6]  = '{1'b1, 32'd204,       32'hFFFF_FFFE,   1'b0, 8'd3};
    tbl[7]  = '{1'b1, 32'd204,       32'h8000_0001,   1'b1, 8'd4};
    tbl[8]  = '{1'b1, 32'h8000_00CC, 32'd0,           1'b1, 8'd4};
    tbl[9]  = '{1'b1, 32'd205,       32'd0,           1'b1, 8'd4};
    tbl[10] = '{1'b1, 32'd204,       32'd2,           1'b0, 8'd4};
    tbl[11] = '{1'b1, 32'd204,       32'd3,           1'b1, 8'd5};
    tbl[12] = '{1'b1, 32'd204,       32'd0,           1'b0, 8'd5};
    tbl[13] = '{1'b0, 32'd204,       32'd1,           1'b0, 8'd5};

    #12;
    check("rst_start", {31'd0, startIO}, 32'd0);
    check("rst_stable", {31'd0, btn_stable}, 32'd0);
    check("rst_count", {24'd0, start_count}, 32'd0);
    rst = 1'b1;
    step();
    step();

    // clean press
    btn_in = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      check($sformatf("press_stable_e%0d", i),
            {31'd0, btn_stable}, {31'd0, i >= 5});
      check($sformatf("press_start_e%0d", i),
            {31'd0, startIO}, {31'd0, i >= 6});
    end
    check("press_count", {24'd0, start_count}, 32'd1);

    // ack while held, no retrigger
    bus(1'b1, 32'd204, 32'd0);
    step();
    bus(1'b0, 32'd0, 32'd0);
    check("ack_start", {31'd0, startIO}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      step();
      check("held_start", {31'd0, startIO}, 32'd0);
    end
    check("held_count", {24'd0, start_count}, 32'd1);
    btn_in = 1'b0;
    repeat (8) step();
    check("rel_stable", {31'd0, btn_stable}, 32'd0);
    check("rel_start", {31'd0, startIO}, 32'd0);
    btn_in = 1'b1;
    repeat (D + 2) step();
    check("repress_early", {31'd0, startIO}, 32'd0);
    step();
    check("repress_start", {31'd0, startIO}, 32'd1);
    check("repress_count", {24'd0, start_count}, 32'd2);
    bus(1'b1, 32'd204, 32'd0);
    step();
    bus(1'b0, 32'd0, 32'd0);
    check("ack2_start", {31'd0, startIO}, 32'd0);
    btn_in = 1'b0;
    repeat (8) step();

    // glitch shorter than the debounce window
    btn_in = 1'b1;
    repeat (3) step();
    btn_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("glitch_stable", {31'd0, btn_stable}, 32'd0);
    end
    check("glitch_start", {31'd0, startIO}, 32'd0);
    check("glitch_count", {24'd0, start_count}, 32'd2);

    // bus decode vectors
    for (int i = 0; i < 14; i++) begin
      bus(tbl[i].we, tbl[i].a2, tbl[i].wd);
      step();
      check($sformatf("vec%0d_start", i),
            {31'd0, startIO}, {31'd0, tbl[i].exp_s});
      check($sformatf("vec%0d_count", i),
            {24'd0, start_count}, {24'd0, tbl[i].exp_c});
    end
    bus(1'b0, 32'd0, 32'd0);

    // async reset while active
    bus(1'b1, 32'd204, 32'd1);
    step();
    bus(1'b0, 32'd0, 32'd0);
    check("pre_rst_start", {31'd0, startIO}, 32'd1);
    check("pre_rst_count", {24'd0, start_count}, 32'd6);
    btn_in = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("arst_start", {31'd0, startIO}, 32'd0);
    check("arst_count", {24'd0, start_count}, 32'd0);
    #2;
    rst = 1'b1;
    for (int i = 1; i <= D + 3; i++) begin
      step();
      check($sformatf("rearm_start_e%0d", i),
            {31'd0, startIO}, {31'd0, i == D + 3});
    end
    check("rearm_count", {24'd0, start_count}, 32'd1);

    // saturation via clear/set toggling, button still held
    c = 1;
    for (int k = 0; k < 260; k++) begin
      bus(1'b1, 32'd204, 32'd0);
      step();
      check("sat_clr_start", {31'd0, startIO}, 32'd0);
      bus(1'b1, 32'd204, 32'd1);
      step();
      c = (c < 255) ? c + 1 : 255;
      check("sat_set_start", {31'd0, startIO}, 32'd1);
      check("sat_count", {24'd0, start_count}, c);
    end
    bus(1'b0, 32'd0, 32'd0);
    step();
    check("sat_final", {24'd0, start_count}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
